unsigned_up_syncreset_mod_counter: RTL



---
 rtl/unsigned_up_syncreset_mod_counter.sv | 90 +++++++++
 1 files changed

// File: rtl/unsigned_up_syncreset_mod_counter.sv
// Modulo-MOD unsigned up counter with synchronous reset, saturating parallel load,
// cascade terminal count, one-cycle wrap pulse and a sticky overflow flag.
// Optional input prescaler on CE is enabled by defining UP_COUNTER_PRESCALE_EN.
module unsigned_up_syncreset_mod_counter #(
  parameter int W   = 4,
  parameter int MOD = 16
`ifdef UP_COUNTER_PRESCALE_EN
  ,
  parameter int PRE = 4
`endif
) (
  input  logic         C,
  input  logic         R,
  input  logic         CE,
  input  logic         L,
  input  logic [W-1:0] D,
  input  logic         OVF_CLR,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         WRAP,
  output logic         OVF
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  if (MOD < 2 || MOD > (2 ** W)) begin : g_bad_mod
    $error("MOD must lie in 2..2**W");
  end

  // Loads above the top count clamp to it so Q never leaves 0..MOD-1.
  function automatic logic [W-1:0] sat_load(input logic [W-1:0] v);
    return (v > LAST) ? LAST : v;
  endfunction

  logic at_last;
  logic pre_last;
  logic adv;

  assign at_last = (Q == LAST);

`ifdef UP_COUNTER_PRESCALE_EN
  localparam int PW = (PRE > 2) ? $clog2(PRE) : 1;

  if (PRE < 2) begin : g_bad_pre
    $error("PRE must be at least 2");
  end

  logic [PW-1:0] pre_cnt;

  assign pre_last = (pre_cnt == PW'(PRE - 1));

  always_ff @(posedge C) begin
    if (R || L) begin
      pre_cnt <= '0;
    end else if (CE) begin
      pre_cnt <= pre_last ? '0 : pre_cnt + PW'(1);
    end
  end
`else
  assign pre_last = 1'b1;
`endif

  assign adv = CE & pre_last;

  // Zero-latency so a following stage's CE sees it on the same edge.
  assign TC = CE & ~R & ~L & at_last & pre_last;

  always_ff @(posedge C) begin
    if (R) begin
      Q    <= '0;
      WRAP <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (L) begin
        Q <= sat_load(D);
      end else if (adv) begin
        Q <= at_last ? '0 : Q + W'(1);
      end
      // A wrap outranks a same-cycle clear of the sticky flag.
      if (!L && adv && at_last) begin
        WRAP <= 1'b1;
        OVF  <= 1'b1;
      end else if (OVF_CLR) begin
        OVF <= 1'b0;
      end
    end
  end

endmodule
